// File: rtl/fpu_arbiter_if.sv
// +--------------------------------------------------------------------+
// | fpu_arbiter_if : requester-side bus of the shared-fpu arbiter       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface fpu_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] op_a;
  logic [32*N_REQ-1:0] op_b;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    resp_valid;
  logic [31:0]         resp_data;
  logic [3:0]          resp_status;

  modport master (
    output req, op_a, op_b,
    input  gnt, resp_valid, resp_data, resp_status
  );

  modport slave (
    input  req, op_a, op_b,
    output gnt, resp_valid, resp_data, resp_status
  );
endinterface

`default_nettype wire

// File: rtl/fpu_arbiter.sv
// +--------------------------------------------------------------------+
// | fpu_arbiter : round-robin sharing of one fpu between N_REQ clients  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fpu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int FPU_LAT = 5,
  parameter int CNT_W   = 16
) (
  input  wire logic             clock100KHz,
  input  wire logic             reset,
  fpu_arbiter_if.slave          bus,
  output logic                  busy,
  input  wire logic             flags_clr,
  output logic [2:0]            sticky_flags,
  output logic [CNT_W-1:0]      op_count,
  output logic [31:0]           fpu_op_a,
  output logic [31:0]           fpu_op_b,
  output logic                  fpu_rst_n,
  input  wire logic [31:0]      fpu_data,
  input  wire logic [3:0]       fpu_status
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = $clog2(FPU_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_idx, r_ptr, w_win;
  logic             w_found;
  logic [CW-1:0]    r_cnt;
  logic [31:0]      r_op_a, r_op_b, r_resp_data;
  logic [3:0]       r_resp_status;
  logic [2:0]       r_sticky, w_set;
  logic [CNT_W-1:0] r_op_count;
  logic             r_fpu_rst_n;

  function automatic logic [IDX_W-1:0] f_wrap(input int v);
    return IDX_W'(v % N_REQ);
  endfunction

  // First requester at or above the pointer, wrapping round.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && bus.req[f_wrap(int'(r_ptr) + k)]) begin
        w_found = 1'b1;
        w_win   = f_wrap(int'(r_ptr) + k);
      end
    end
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_next = S_GRANT;
      S_GRANT:   w_next = S_RUN;
      S_RUN:     if (r_cnt == CW'(FPU_LAT - 1)) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_set = 3'b000;
    if (r_state == S_RESP) begin
      case (r_resp_status)
        4'd1:    w_set = 3'b001;
        4'd2:    w_set = 3'b010;
        4'd3:    w_set = 3'b100;
        default: w_set = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_idx         <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_resp_data   <= '0;
      r_resp_status <= '0;
      r_sticky      <= '0;
      r_op_count    <= '0;
      r_fpu_rst_n   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) r_idx <= w_win;
        S_GRANT: begin
          r_op_a <= bus.op_a[{r_idx, 5'b00000} +: 32];
          r_op_b <= bus.op_b[{r_idx, 5'b00000} +: 32];
          r_ptr  <= (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
          r_cnt  <= '0;
        end
        S_RUN: r_cnt <= r_cnt + 1'b1;
        S_CAPTURE: begin
          r_resp_data   <= fpu_data;
          r_resp_status <= fpu_status;
        end
        S_RESP: r_op_count <= r_op_count + 1'b1;
        default: ;
      endcase
      // Registered so the fpu sees a clean one-cycle low pulse during GRANT.
      r_fpu_rst_n <= (w_next != S_GRANT);
      // A flag raised by the completing op survives a simultaneous clear.
      r_sticky    <= (flags_clr ? 3'b000 : r_sticky) | w_set;
    end
  end

  assign bus.gnt         = (r_state == S_GRANT) ? (N_REQ'(1) << r_idx) : '0;
  assign bus.resp_valid  = (r_state == S_RESP)  ? (N_REQ'(1) << r_idx) : '0;
  assign bus.resp_data   = r_resp_data;
  assign bus.resp_status = r_resp_status;
  assign busy            = (r_state != S_IDLE);
  assign sticky_flags    = r_sticky;
  assign op_count        = r_op_count;
  assign fpu_op_a        = r_op_a;
  assign fpu_op_b        = r_op_b;
  assign fpu_rst_n       = r_fpu_rst_n;

endmodule

`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_fpu_arbiter : self-checking bench with an fpu stub and rr model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fpu_arbiter;
  localparam int N   = 4;
  localparam int LAT = 5;
  localparam int CW  = 2;

  logic          clock100KHz = 1'b0;
  logic          reset       = 1'b0;
  logic          flags_clr   = 1'b0;
  logic          busy;
  logic [2:0]    sticky_flags;
  logic [CW-1:0] op_count;
  logic [31:0]   fpu_op_a, fpu_op_b, fpu_data;
  logic          fpu_rst_n;
  logic [3:0]    fpu_status;

  always #5 clock100KHz = ~clock100KHz;

  fpu_arbiter_if #(.N_REQ(N)) bus ();

  fpu_arbiter #(.N_REQ(N), .FPU_LAT(LAT), .CNT_W(CW)) dut (
    .clock100KHz  (clock100KHz),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags),
    .op_count     (op_count),
    .fpu_op_a     (fpu_op_a),
    .fpu_op_b     (fpu_op_b),
    .fpu_rst_n    (fpu_rst_n),
    .fpu_data     (fpu_data),
    .fpu_status   (fpu_status)
  );

  function automatic logic [31:0] mix(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  // fpu stub: result is only valid exactly LAT cycles after reset release.
  logic [7:0] age;
  always @(posedge clock100KHz) begin
    if (!fpu_rst_n)          age <= 8'd0;
    else if (age != 8'hFF)   age <= age + 8'd1;
  end
  assign fpu_data   = (age == 8'(LAT)) ? mix(fpu_op_a, fpu_op_b) : (32'hBAD0_0000 | {24'h0, age});
  assign fpu_status = (age == 8'(LAT)) ? (fpu_op_a[3:0] ^ fpu_op_b[3:0]) : 4'hF;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] a_arr[N];
  logic [31:0] b_arr[N];
  int          m_ptr;
  logic [2:0]  m_sticky;
  int          m_count;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    a_arr[i] = a;
    b_arr[i] = b;
    bus.op_a[32*i +: 32] = a;
    bus.op_b[32*i +: 32] = b;
    bus.req[i] = 1'b1;
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_sticky = 3'b000;
    m_count  = 0;
  endtask

  // Called at an IDLE-cycle negedge with at least one request pending.
  task automatic run_op(input logic clr_at_resp, output int widx);
    int          wait_n;
    int          exp;
    logic [N-1:0] rq;
    logic [31:0] ed;
    logic [3:0]  es;
    logic [2:0]  set;
    rq     = bus.req;
    wait_n = 0;
    do begin
      @(negedge clock100KHz);
      wait_n++;
    end while (bus.gnt == '0 && wait_n < 20);
    exp = rr_pick(rq, m_ptr);
    chk("gnt_onehot", 32'(bus.gnt), 32'(1 << exp));
    chk("gnt_latency", 32'(wait_n), 32'd1);
    chk("fpu_rst_n_grant", 32'(fpu_rst_n), 32'd0);
    widx = exp;
    if (bus.gnt == '0) return;
    bus.req[exp] = 1'b0;
    m_ptr = (exp + 1) % N;
    ed = mix(a_arr[exp], b_arr[exp]);
    es = a_arr[exp][3:0] ^ b_arr[exp][3:0];
    @(negedge clock100KHz);
    chk("fpu_op_a", fpu_op_a, a_arr[exp]);
    chk("fpu_op_b", fpu_op_b, b_arr[exp]);
    chk("fpu_rst_n_run", 32'(fpu_rst_n), 32'd1);
    wait_n = 1;
    while (bus.resp_valid == '0 && wait_n < 30) begin
      @(negedge clock100KHz);
      wait_n++;
    end
    chk("resp_latency", 32'(wait_n), 32'(LAT + 2));
    chk("resp_valid", 32'(bus.resp_valid), 32'(1 << exp));
    chk("resp_data", bus.resp_data, ed);
    chk("resp_status", 32'(bus.resp_status), 32'(es));
    chk("busy_resp", 32'(busy), 32'd1);
    case (es)
      4'd1:    set = 3'b001;
      4'd2:    set = 3'b010;
      4'd3:    set = 3'b100;
      default: set = 3'b000;
    endcase
    if (clr_at_resp) begin
      flags_clr = 1'b1;
      m_sticky  = set;
    end else begin
      m_sticky = m_sticky | set;
    end
    m_count = (m_count + 1) % (1 << CW);
    @(negedge clock100KHz);
    flags_clr = 1'b0;
    chk("op_count", 32'(op_count), 32'(m_count));
    chk("sticky", 32'(sticky_flags), 32'(m_sticky));
    chk("busy_idle", 32'(busy), 32'd0);
    chk("resp_valid_off", 32'(bus.resp_valid), 32'd0);
  endtask

  typedef struct {
    logic [N-1:0] add;
    int           exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int w;
    int pulses;
    tbl[0] = '{4'b1111, 0};
    tbl[1] = '{4'b0000, 1};
    tbl[2] = '{4'b0000, 2};
    tbl[3] = '{4'b0000, 3};
    tbl[4] = '{4'b1001, 0};
    tbl[5] = '{4'b0000, 3};
    tbl[6] = '{4'b1011, 0};
    tbl[7] = '{4'b0000, 1};
    tbl[8] = '{4'b0000, 3};

    bus.req  = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    model_reset();
    repeat (3) @(negedge clock100KHz);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_status", 32'(bus.resp_status), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_fpu_op_a", fpu_op_a, 32'd0);
    chk("rst_fpu_op_b", fpu_op_b, 32'd0);
    chk("rst_fpu_rst_n", 32'(fpu_rst_n), 32'd0);
    reset = 1'b1;

    // Round-robin order and wrap-around
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < N; j++)
        if (tbl[i].add[j]) set_req(j, $urandom, $urandom);
      run_op(1'b0, w);
      chk("rr_order", 32'(w), 32'(tbl[i].exp));
    end

    // Single op with the reference operand pair
    set_req(0, 32'h3E00_0000, 32'h3E00_0000);
    run_op(1'b0, w);
    chk("single_idx", 32'(w), 32'd0);
    chk("single_data", bus.resp_data, 32'h7C00_0000);

    // Sticky flags: clear, overflow, inexact, then clear racing an underflow
    flags_clr = 1'b1;
    @(negedge clock100KHz);
    flags_clr = 1'b0;
    m_sticky  = 3'b000;
    chk("sticky_clr", 32'(sticky_flags), 32'd0);
    set_req(1, 32'h4000_0002, 32'h0000_0000);
    run_op(1'b0, w);
    chk("sticky_ovf", 32'(sticky_flags), 32'b010);
    set_req(2, 32'h4000_0001, 32'h0000_0000);
    run_op(1'b0, w);
    chk("sticky_inx", 32'(sticky_flags), 32'b011);
    set_req(3, 32'h4000_0003, 32'h0000_0000);
    run_op(1'b1, w);
    chk("sticky_clr_set", 32'(sticky_flags), 32'b100);

    // Reset during RUN with cnt==2 aborts the op
    set_req(1, 32'h1234_5678, 32'h0000_1111);
    w = 0;
    do begin
      @(negedge clock100KHz);
      w++;
    end while (bus.gnt == '0 && w < 20);
    chk("abort_gnt", 32'(bus.gnt), 32'b0010);
    bus.req[1] = 1'b0;
    repeat (3) @(negedge clock100KHz);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_fpu_rst_n", 32'(fpu_rst_n), 32'd0);
    chk("abort_resp_data", bus.resp_data, 32'd0);
    chk("abort_op_count", 32'(op_count), 32'd0);
    chk("abort_fpu_op_a", fpu_op_a, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock100KHz);
      if (bus.resp_valid != '0) pulses++;
    end
    chk("abort_no_resp", 32'(pulses), 32'd0);
    reset = 1'b1;
    model_reset();
    set_req(2, 32'h0BAD_F00D, 32'h0000_0042);
    run_op(1'b0, w);
    chk("after_abort_idx", 32'(w), 32'd2);

    // Randomised traffic against the round-robin model
    for (int n = 0; n < 60; n++) begin
      for (int j = 0; j < N; j++)
        if (!bus.req[j] && $urandom_range(1, 0) == 1) set_req(j, $urandom, $urandom);
      if (bus.req == '0) set_req(int'($urandom_range(N - 1, 0)), $urandom, $urandom);
      run_op($urandom_range(7, 0) == 0, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares a single fpu instance between N_REQ requesters using round-robin arbitration.
- Sequences each operation: latches the granted operands and pulses the fpu reset low for one cycle so the fpu state machine starts phase-aligned. It then waits out the fpu pipeline, captures data_out/status_out and returns them to the winning requester.
- Keeps sticky exception flags and a completed-operation counter for software/debug.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- FPU_LAT, 5, fpu cycles after reset release until data_out is valid (MOD_EXPO..PARA_STATUS)
- CNT_W, 16, width of op_count

Ports:
- clock100KHz  in  1  system clock
- reset  in  1  asynchronous, active-low
- req  in  N_REQ  request per requester; held high with operands stable until gnt
- op_a  in  32*N_REQ  operand A per requester; requester i uses slice [32*i+31:32*i]
- op_b  in  32*N_REQ  operand B per requester, same slicing
- gnt  out  N_REQ  one-hot, one-cycle pulse when the requester's operands are latched
- resp_valid  out  N_REQ  one-hot, one-cycle pulse with the result
- resp_data  out  32  result of the last completed op
- resp_status  out  4  fpu status of the last completed op (0 EXACT, 1 INEXACT, 2 OVERFLOW, 3 UNDERFLOW)
- busy  out  1  high in every state except IDLE
- flags_clr  in  1  synchronous clear of sticky_flags
- sticky_flags  out  3  {underflow, overflow, inexact}, OR-accumulated
- op_count  out  CNT_W  completed operations, wraps
- fpu_op_a  out  32  to fpu op_A_in
- fpu_op_b  out  32  to fpu op_B_in
- fpu_rst_n  out  1  to fpu reset; registered
- fpu_data  in  32  from fpu data_out
- fpu_status  in  4  from fpu status_out

Behaviour:
- Reset (reset=0) clears all outputs and registers: state IDLE, gnt=0, resp_valid=0, resp_data=0, resp_status=0, busy=0, sticky_flags=0, op_count=0, fpu_op_a=0, fpu_op_b=0, fpu_rst_n=0, rr pointer=0.
- Holding fpu_rst_n=0 while the controller is in reset keeps the fpu in reset with it. Reset mid-operation aborts the op; no resp_valid is issued for it.
- States: IDLE, GRANT, RUN, CAPTURE, RESP.
- IDLE:
  - fpu_rst_n=1.
  - If any req bit is high, pick the winner by round-robin starting at the rr pointer, giving the lowest index at or above the pointer, wrapping.
  - Next state GRANT; the winner index is registered.
- GRANT (1 cycle):
  - gnt[idx]=1.
  - fpu_rst_n=0.
  - fpu_op_a/fpu_op_b are loaded with the winner's slices at the end of this cycle.
  - rr pointer becomes (idx+1) mod N_REQ.
  - Next state RUN with cnt=0.
- RUN:
  - fpu_rst_n=1.
  - fpu_op_a/b are held constant.
  - cnt increments each cycle; when cnt==FPU_LAT-1, go to CAPTURE.
  - RUN lasts exactly FPU_LAT cycles.
- CAPTURE (1 cycle): at the ending edge, resp_data<=fpu_data and resp_status<=fpu_status; next state RESP.
- RESP (1 cycle):
  - resp_valid[idx]=1.
  - op_count increments (wraps 2^CNT_W-1 -> 0).
  - sticky_flags bits are set per resp_status: 1 sets inexact, 2 sets overflow, 3 sets underflow.
  - Next state IDLE.
- Latency: req sampled high in IDLE cycle t -> gnt in cycle t+1 -> resp_valid in cycle t+3+FPU_LAT (t+8 at default).
- Throughput: one op per FPU_LAT+4 cycles. Back-to-back requests incur one IDLE cycle between ops.
- Requester rules:
  - Operands are sampled only during GRANT.
  - The requester must drop req the cycle after gnt. A req still high in the next IDLE is treated as a new request.
  - A req that drops before grant is never serviced.
- Requests arriving while busy wait; no loss, no queue beyond the req level.
- flags_clr takes effect at the next edge in any state. If it coincides with a RESP that sets a flag, the set wins.
- resp_data/resp_status hold their value until the next CAPTURE.
- Values of resp_status other than 0..3 set no flag.

Test Plan:
- Single op: req[0]=1, op_a=0x3E000000, op_b=0x3E000000 -> gnt[0] at t+1, fpu_rst_n low exactly that cycle, resp_valid[0] at t+8 with resp_data equal to the fpu output for that pair, op_count=1.
- Round-robin: req=4'b1111 held, each requester drops req after its gnt -> grant order 0,1,2,3. Then req=4'b1001 with pointer 0 -> grant 0, then 3.
- Fairness/wrap: after granting 3, req=4'b1011 -> grant 0, then 1, then 3. Each gnt/resp_valid is one-hot and indices match.
- Reset mid-op: assert reset during RUN cnt=2 -> all outputs reset values, fpu_rst_n=0, no resp_valid. After release with req[2]=1, a normal op completes.
- Sticky/clear: fpu_status stubbed to 2 then 1 -> sticky_flags=3'b010 then 3'b011. flags_clr asserted with a concurrent RESP carrying status 3 -> 3'b100.
- Counter wrap: CNT_W=2, 5 ops -> op_count sequence 1,2,3,0,1.
